// File: rtl/regb_pkg.sv
// Shared types and helpers for the FIFO packet packer.
package regb_pkg;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    // Width needed to hold a word count in the range 0..k.
    function automatic int cnt_width(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/regb_fifo_packer_if.sv
// FIFO-side and packet-side signals of the packer; slave is the packer's view.
interface regb_fifo_packer_if #(
    parameter int WIDTH = 4,
    parameter int K     = 4
);
    localparam int CW = regb_pkg::cnt_width(K);

    logic [WIDTH-1:0]   fifo_rdata;
    logic               fifo_empty;
    logic               fifo_shift_out;
    logic               flush;
    logic [K*WIDTH-1:0] out_data;
    logic [CW-1:0]      out_cnt;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport slave (
        input  fifo_rdata, fifo_empty, flush, out_ready,
        output fifo_shift_out, out_data, out_cnt, out_valid, busy
    );

    modport master (
        output fifo_rdata, fifo_empty, flush, out_ready,
        input  fifo_shift_out, out_data, out_cnt, out_valid, busy
    );
endinterface

// File: rtl/regb_fifo_packer.sv
// Pops words from a register FIFO and packs K of them into one packet;
// flush emits a zero-padded partial packet with its word count.
module regb_fifo_packer
    import regb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int K     = 4
) (
    input  logic              clk,
    input  logic              res,
    regb_fifo_packer_if.slave bus
);
    localparam int CW = cnt_width(K);
    localparam int IW = $clog2(K);

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_out_cnt;
    logic            r_out_valid;
    logic            w_pop;
    logic            w_accept;
    logic [K-1:0]    w_lane_we;

    // The pop strobe depends only on registered state and the empty flag.
    assign w_pop    = (r_state == FILL) && !bus.fifo_empty;
    assign w_accept = (r_state == OUT) && bus.out_ready;

    assign bus.fifo_shift_out = w_pop;
    assign bus.out_cnt        = r_out_cnt;
    assign bus.out_valid      = r_out_valid;
    assign bus.busy           = (r_state == OUT) || (r_idx != '0);

    for (genvar g = 0; g < K; g++) begin : g_lane
        logic [WIDTH-1:0] r_lane;

        assign w_lane_we[g] = w_pop && (r_idx == IW'(g));

        // Lane storage; cleared on acceptance so partial packets pad with zero.
        always_ff @(posedge clk or posedge res) begin
            if (res) begin
                r_lane <= '0;
            end else if (w_accept) begin
                r_lane <= '0;
            end else if (w_lane_we[g]) begin
                r_lane <= bus.fifo_rdata;
            end
        end

        assign bus.out_data[g*WIDTH +: WIDTH] = r_lane;
    end

    // Fill/hand-off state machine with registered count and valid.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state     <= FILL;
            r_idx       <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_pop) begin
                        if ((r_idx == IW'(K - 1)) || bus.flush) begin
                            r_state     <= OUT;
                            r_out_cnt   <= CW'(r_idx) + CW'(1);
                            r_out_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else if (bus.flush && (r_idx != '0)) begin
                        r_state     <= OUT;
                        r_out_cnt   <= CW'(r_idx);
                        r_out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_state     <= FILL;
                        r_idx       <= '0;
                        r_out_cnt   <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_idx       <= '0;
                    r_out_cnt   <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regb_fifo_packer.sv
// Directed test-plan sequences plus random traffic against a queue-based packet model.
module tb_regb_fifo_packer;
    localparam int WIDTH = 4;
    localparam int K     = 4;

    logic clk;
    logic res;
    int   n_tests;
    int   n_fail;

    regb_fifo_packer_if #(.WIDTH(WIDTH), .K(K)) bus ();

    regb_fifo_packer #(.WIDTH(WIDTH), .K(K)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: the external FIFO, the words collected so far, and a pending packet.
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] m_words[$];
    bit               m_pend;
    logic [15:0]      m_pkt_data;
    int               m_pkt_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        fq.delete();
        m_words.delete();
        m_pend     = 1'b0;
        m_pkt_data = '0;
        m_pkt_cnt  = 0;
    endtask

    task automatic m_emit();
        m_pkt_data = '0;
        foreach (m_words[i]) m_pkt_data = m_pkt_data | (16'(m_words[i]) << (i * WIDTH));
        m_pkt_cnt = m_words.size();
        m_words.delete();
        m_pend = 1'b1;
    endtask

    task automatic fifo_push(input logic [WIDTH-1:0] v);
        fq.push_back(v);
    endtask

    // One clock: drive inputs at the falling edge, predict the rising edge, compare after it.
    task automatic tick(input bit fl, input bit rdy);
        bit pop;
        bus.flush      = fl;
        bus.out_ready  = rdy;
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_rdata = (fq.size() != 0) ? fq[0] : 4'h0;
        #1;
        pop = !m_pend && (fq.size() != 0);
        check_val("shift_out", {63'd0, bus.fifo_shift_out}, {63'd0, pop});
        if (m_pend) begin
            if (rdy) m_pend = 1'b0;
        end else if (pop) begin
            m_words.push_back(fq.pop_front());
            if (m_words.size() == K || fl) m_emit();
        end else if (fl && m_words.size() != 0) begin
            m_emit();
        end
        @(negedge clk);
        check_val("out_valid", {63'd0, bus.out_valid}, {63'd0, m_pend});
        check_val("busy", {63'd0, bus.busy}, {63'd0, (m_pend || m_words.size() != 0)});
        if (m_pend) begin
            check_val("out_data", 64'(bus.out_data), 64'(m_pkt_data));
            check_val("out_cnt", 64'(bus.out_cnt), 64'(m_pkt_cnt));
        end else begin
            check_val("out_cnt_idle", 64'(bus.out_cnt), 64'd0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_reset();
        res            = 1'b1;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = 4'h0;
        #2;
        check_val("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check_val("rst_data", 64'(bus.out_data), 64'd0);
        check_val("rst_cnt", 64'(bus.out_cnt), 64'd0);
        check_val("rst_busy", {63'd0, bus.busy}, 64'd0);
        check_val("rst_shift", {63'd0, bus.fifo_shift_out}, 64'd0);
        @(negedge clk);
        res = 1'b0;

        // Full packet held with out_ready low; 5 and 6 wait in the FIFO meanwhile.
        for (int i = 1; i <= 4; i++) fifo_push(4'(i));
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        check_val("full_not_yet", {63'd0, bus.out_valid}, 64'd0);
        tick(1'b0, 1'b0);
        check_val("full_valid", {63'd0, bus.out_valid}, 64'd1);
        check_val("full_data", 64'(bus.out_data), 64'h4321);
        check_val("full_cnt", 64'(bus.out_cnt), 64'd4);
        fifo_push(4'h5);
        fifo_push(4'h6);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            check_val("hold_data", 64'(bus.out_data), 64'h4321);
            check_val("hold_no_pop", {63'd0, bus.fifo_shift_out}, 64'd0);
        end
        tick(1'b0, 1'b1);

        // Flush with FIFO empty after two words.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_val("flush_data", 64'(bus.out_data), 64'h0065);
        check_val("flush_cnt", 64'(bus.out_cnt), 64'd2);
        tick(1'b0, 1'b1);
        check_val("flush_busy", {63'd0, bus.busy}, 64'd0);

        // Flush coinciding with a pop includes the popped word.
        fifo_push(4'h7);
        tick(1'b0, 1'b0);
        fifo_push(4'h8);
        tick(1'b1, 1'b0);
        check_val("popflush_data", 64'(bus.out_data), 64'h0087);
        check_val("popflush_cnt", 64'(bus.out_cnt), 64'd2);
        tick(1'b0, 1'b1);

        // Flush with nothing held is ignored.
        tick(1'b1, 1'b0);
        check_val("empty_flush_valid", {63'd0, bus.out_valid}, 64'd0);
        check_val("empty_flush_busy", {63'd0, bus.busy}, 64'd0);

        // Streaming with out_ready held high: accept on edge 5, second packet valid after edge 9.
        for (int i = 1; i <= 8; i++) fifo_push(4'(i));
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b1);
            if (i == 4) check_val("stream_pkt0", 64'(bus.out_data), 64'h4321);
            if (i == 5) check_val("stream_idle", {63'd0, bus.out_valid}, 64'd0);
            if (i == 9) check_val("stream_pkt1", 64'(bus.out_data), 64'h8765);
            if (i == 9) check_val("stream_valid1", {63'd0, bus.out_valid}, 64'd1);
        end
        check_val("stream_done", {63'd0, bus.busy}, 64'd0);

        // Asynchronous reset mid-packet discards held words.
        for (int i = 1; i <= 3; i++) fifo_push(4'hE);
        fifo_push(4'hE);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        #2;
        res = 1'b1;
        #1;
        check_val("arst_busy", {63'd0, bus.busy}, 64'd0);
        check_val("arst_data", 64'(bus.out_data), 64'd0);
        check_val("arst_cnt", 64'(bus.out_cnt), 64'd0);
        check_val("arst_valid", {63'd0, bus.out_valid}, 64'd0);
        m_reset();
        bus.fifo_empty = 1'b1;
        #1;
        check_val("arst_shift", {63'd0, bus.fifo_shift_out}, 64'd0);
        @(negedge clk);
        res = 1'b0;
        fifo_push(4'h9);
        fifo_push(4'hA);
        fifo_push(4'hB);
        fifo_push(4'hC);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        check_val("post_rst_data", 64'(bus.out_data), 64'hCBA9);
        tick(1'b0, 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) != 0 && fq.size() < 6) fifo_push(4'($urandom));
            tick(($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
